// File: rtl/vn_cpu_pkg.sv
// vn_cpu_pkg: opcodes, FSM states and instruction field positions for the core
package vn_cpu_pkg;
  localparam int OPC_W    = 4;
  localparam int REG_W    = 2;
  localparam int DREG_LSB = 2;
  localparam int SREG_LSB = 0;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_LDI  = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_HALT = 4'd15
  } opcode_t;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;
endpackage

// File: rtl/vn_cpu_alu.sv
// vn_cpu_alu: combinational ALU, the single adder shared by datapath and pc increment
module vn_cpu_alu import vn_cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              negative
);
  logic              sub;
  logic [DATA_W:0]   sum;
  always_comb begin
    sub      = op == OP_SUB;
    sum      = {1'b0, a} + {1'b0, sub ? ~b : b} + {{DATA_W{1'b0}}, sub};
    result   = op == OP_AND ? a & b : op == OP_OR ? a | b : sum[DATA_W-1:0];
    carry    = (op == OP_ADD || sub) && sum[DATA_W];
    zero     = result == '0;
    negative = result[DATA_W-1];
  end
endmodule

// File: rtl/vn_cpu_core.sv
// vn_cpu_core: multi-cycle von Neumann core with four registers and a ready-handshaked memory port
module vn_cpu_core import vn_cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              halted
);
  state_t            state, state_nx;
  opcode_t           op, alu_op;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] ir, immr, alu_a, alu_b, alu_res;
  logic [REG_W-1:0]  rd, rs;
  logic              done, is_alu, needs_imm, take_jmp, alu_c, alu_z, alu_n;
  assign done = mem_req && mem_ready;
  // outside EXEC the ALU is borrowed to compute pc + 1
  always_comb begin
    op        = opcode_t'(ir[DATA_W-1 -: OPC_W]);
    rd        = ir[DREG_LSB +: REG_W];
    rs        = ir[SREG_LSB +: REG_W];
    is_alu    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    needs_imm = op inside {OP_LDI, OP_JMP, OP_JZ, OP_JN};
    take_jmp  = op == OP_JMP || (op == OP_JZ && zero) || (op == OP_JN && negative);
    alu_op    = state == S_EXEC ? op : OP_ADD;
    alu_a     = state == S_EXEC ? rf[rd] : pc;
    alu_b     = state == S_EXEC ? rf[rs] : {{(DATA_W-1){1'b0}}, 1'b1};
  end
  vn_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op(alu_op), .a(alu_a), .b(alu_b),
    .result(alu_res), .carry(alu_c), .zero(alu_z), .negative(alu_n)
  );
  always_ff @(posedge clk) state <= reset ? S_FETCH : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = done ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = needs_imm ? S_IMM : S_EXEC;
      S_IMM:    state_nx = done ? S_EXEC : S_IMM;
      S_EXEC:   state_nx = op inside {OP_LD, OP_ST} ? S_MEM : op == OP_HALT ? S_HALT : S_FETCH;
      S_MEM:    state_nx = done ? S_FETCH : S_MEM;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end
  always_comb begin
    mem_req   = !reset && state inside {S_FETCH, S_IMM, S_MEM};
    mem_we    = state == S_MEM && op == OP_ST;
    mem_addr  = state == S_MEM ? rf[rs] : pc;
    mem_wdata = rf[rd];
    halted    = state == S_HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      pc       <= '0;
      ir       <= '0;
      immr     <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
    end else begin
      if (state == S_FETCH && done) begin
        ir <= mem_rdata;
        pc <= alu_res;
      end
      if (state == S_IMM && done) begin
        immr <= mem_rdata;
        pc   <= alu_res;
      end
      if (state == S_EXEC && is_alu) begin
        rf[rd]   <= alu_res;
        zero     <= alu_z;
        negative <= alu_n;
        carry    <= alu_c;
      end
      if (state == S_EXEC && op == OP_LDI) rf[rd] <= immr;
      if (state == S_EXEC && take_jmp) pc <= immr;
      if (state == S_MEM && done && op == OP_LD) rf[rd] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vn_cpu_core.sv
// tb_vn_cpu_core: directed and random programs checked against an instruction-level model
module tb_vn_cpu_core;
  logic       clk = 1'b0, reset = 1'b1, ld = 1'b0;
  logic       mem_req, mem_we, mem_ready, zero, negative, carry, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  int         total = 0, bad = 0, wait_n = 0, cnt = 0, wr_cnt = 0;
  logic [7:0] wr_addr = '0, wr_data = '0;
  logic       was_wait = 1'b0;
  logic [17:0] held = '0;
  int         mm [256];
  int         mr [4];
  int         mpc, mz, mn, mc, mcyc;

  vn_cpu_core #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .zero(zero), .negative(negative),
    .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = cnt >= wait_n;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wr_cnt <= 0;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    cnt <= (reset || !mem_req || mem_ready) ? 0 : cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // request fields must not move while the memory holds off
  always @(negedge clk) begin
    if (!reset && was_wait) check("hold", {mem_req, mem_we, mem_addr, mem_wdata}, {14'd0, held});
    was_wait = !reset && mem_req && !mem_ready;
    held = {mem_req, mem_we, mem_addr, mem_wdata};
  end

  task automatic model_run(input int wn);
    int ins, op, d, s, imm, r, steps;
    bit stop;
    for (int i = 0; i < 256; i++) mm[i] = int'(img[i]);
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mpc = 0; mz = 0; mn = 0; mc = 0; mcyc = 0; steps = 0; stop = 0; imm = 0;
    while (!stop && steps < 2000) begin
      steps++;
      ins = mm[mpc]; op = ins >> 4; d = (ins >> 2) & 3; s = ins & 3;
      mpc = (mpc + 1) % 256;
      mcyc += 3 + wn;
      if (op inside {5, 8, 9, 10}) begin
        imm = mm[mpc]; mpc = (mpc + 1) % 256; mcyc += 1 + wn;
      end
      case (op)
        1, 2, 3, 4: begin
          r  = op == 1 ? mr[d] + mr[s] : op == 2 ? mr[d] - mr[s] : op == 3 ? mr[d] & mr[s] : mr[d] | mr[s];
          mc = op == 1 ? int'(r > 255) : op == 2 ? int'(mr[d] >= mr[s]) : 0;
          r  = r & 255;
          mr[d] = r; mz = int'(r == 0); mn = int'(r >= 128);
        end
        5: mr[d] = imm;
        6: begin mr[d] = mm[mr[s]]; mcyc += 1 + wn; end
        7: begin mm[mr[s]] = mr[d]; mcyc += 1 + wn; end
        8: mpc = imm;
        9: if (mz != 0) mpc = imm;
        10: if (mn != 0) mpc = imm;
        15: stop = 1;
        default: ;
      endcase
    end
  endtask

  task automatic load_img(input logic [63:0] v, input int n);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < n; i++) img[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic reset_load(input int wn);
    @(negedge clk); reset = 1'b1; ld = 1'b1; wait_n = wn;
    @(negedge clk); ld = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int wn, output int cyc);
    int diff;
    model_run(wn);
    reset_load(wn);
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check({tag, "_halt"}, 32'(halted), 32'd1);
    check({tag, "_cyc"}, cyc, mcyc);
    check({tag, "_pc"}, 32'(pc), mpc);
    check({tag, "_flags"}, {zero, negative, carry}, {mz[0], mn[0], mc[0]});
    check({tag, "_regs"}, {dut.rf[0], dut.rf[1], dut.rf[2], dut.rf[3]},
          {8'(mr[0]), 8'(mr[1]), 8'(mr[2]), 8'(mr[3])});
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'(mm[i])) diff++;
    check({tag, "_mem"}, diff, 0);
    repeat (3) @(negedge clk);
    check({tag, "_stay"}, {halted, mem_req, pc}, {1'b1, 1'b0, 8'(mpc)});
  endtask

  task automatic gen_prog();
    int n, a, t, d, s;
    int kind [32];
    int addr [33];
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
    n = $urandom_range(10, 25);
    a = 0;
    for (int k = 0; k < n; k++) begin
      kind[k] = $urandom_range(0, 5);
      addr[k] = a;
      a += kind[k] inside {0, 2} ? 1 : kind[k] inside {1, 5} ? 2 : 3;
    end
    addr[n] = a;
    for (int k = 0; k < n; k++) begin
      a = addr[k]; d = $urandom_range(0, 3); s = $urandom_range(0, 3);
      case (kind[k])
        0: img[a] = 8'(($urandom_range(1, 4) << 4) | (d << 2) | s);
        1: begin img[a] = 8'(8'h50 | (d << 2)); img[a+1] = 8'($urandom_range(0, 255)); end
        2: img[a] = 8'(($urandom_range(0, 1) != 0 ? 0 : $urandom_range(11, 14) << 4) | $urandom_range(0, 15));
        3, 4: begin
          img[a]   = 8'(8'h50 | (s << 2));
          img[a+1] = 8'(8'h80 | $urandom_range(0, 127));
          img[a+2] = 8'((kind[k] == 3 ? 8'h70 : 8'h60) | (d << 2) | s);
        end
        default: begin
          t = $urandom_range(k + 1, n);
          img[a]   = 8'(($urandom_range(8, 10) << 4) | (d << 2) | s);
          img[a+1] = 8'(addr[t]);
        end
      endcase
    end
    img[addr[n]] = 8'(8'hF0 | $urandom_range(0, 15));
  endtask

  initial begin
    int cyc, r;
    repeat (2) @(negedge clk);
    check("rst_state", {mem_req, halted, zero, negative, carry, pc}, 0);
    check("rst_regs", {dut.rf[0], dut.rf[1], dut.rf[2], dut.rf[3]}, 0);

    load_img(64'h500A540511F0, 6);
    run_prog("r035", 0, cyc);
    check("r035_14clk", cyc, 14);
    check("r035_r0", {dut.rf[0], pc, zero, carry}, {8'h0F, 8'h06, 1'b0, 1'b0});

    run_prog("r037", 3, cyc);
    check("r037_32clk", cyc, 32);
    check("r037_r0", {dut.rf[0], pc}, {8'h0F, 8'h06});

    load_img(64'h5000540121F0, 6);
    run_prog("sub01", 0, cyc);
    check("sub01_k", {dut.rf[0], negative, carry, zero}, {8'hFF, 1'b1, 1'b0, 1'b0});
    load_img(64'h5005540521F0, 6);
    run_prog("sub55", 2, cyc);
    check("sub55_k", {dut.rf[0], zero, carry}, {8'h00, 1'b1, 1'b1});
    load_img(64'h50FF540111F0, 6);
    run_prog("addff", 1, cyc);
    check("addff_k", {dut.rf[0], zero, carry}, {8'h00, 1'b1, 1'b1});
    load_img(64'h544115F0, 4);
    run_prog("dbl", 0, cyc);
    check("dbl_k", {dut.rf[1], negative}, {8'h82, 1'b1});

    load_img(64'h2058A55C807B63F0, 8);
    run_prog("stld", 1, cyc);
    check("stld_wr", {wr_cnt[7:0], wr_addr, wr_data}, {8'd1, 8'h80, 8'hA5});
    check("stld_k", {dut.rf[0], zero, carry, negative}, {8'hA5, 1'b1, 1'b1, 1'b0});

    load_img(64'h80FF, 2);
    reset_load(0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("jmp_ff", {pc, mem_req, mem_addr}, {8'hFF, 1'b1, 8'hFF});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("jmp_wrap", {pc, mem_req, mem_addr}, {8'h00, 1'b1, 8'h00});
    load_img(64'h9040F0, 3);
    run_prog("jz_nt", 0, cyc);
    check("jz_nt_k", {pc, 24'(cyc)}, {8'h03, 24'd7});

    load_img(64'h500A540511F0, 6);
    reset_load(0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("r040_pre", {pc, dut.rf[0], dut.rf[1]}, {8'h04, 8'h0A, 8'h05});
    wait_n = 5;
    @(negedge clk);
    check("r040_wait", {mem_req, mem_ready, pc, dut.rf[0]}, {1'b1, 1'b0, 8'h04, 8'h0A});
    reset = 1'b1;
    @(negedge clk);
    check("r040_rst", {mem_req, halted, zero, negative, carry, pc}, 0);
    check("r040_regs", {dut.rf[0], dut.rf[1], dut.rf[2], dut.rf[3]}, 0);
    @(negedge clk);
    wait_n = 0; reset = 1'b0;
    #1;
    check("r040_fetch0", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    @(negedge clk);
    check("r040_ir", {pc, mem_req}, {8'h01, 1'b0});

    for (int k = 0; k < 40; k++) begin
      gen_prog();
      r = $urandom_range(0, 2);
      run_prog("rnd", r == 2 ? 3 : r, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
